uart_rx: RTL and testbench

//   UART receiver, counterpart of the uart_tx transmitter: 8N1 framing, LSB first, same clk_div baud convention.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync.sv | 24 ++
 rtl/uart_rx.sv | 123 ++++++++++++
 tb/tb_uart_rx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants.
// Used by both uart_tx and uart_rx.
package uart_pkg;

  localparam int UART_DIV_W = 16;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } t_rx_state;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for an asynchronous input.
// Flops reset to 1 so an idle-high line shows no false edge.
module uart_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff <= '1;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling.
// Bit period is clk_div+1 cycles, latched per frame.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic [UART_DIV_W-1:0] clk_div,
  output logic [DATA_BITS-1:0]  dout,
  output logic                  done,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_BIT =
    BCW'(DATA_BITS - 1);

  t_rx_state             state;
  logic                  rx_s;
  logic                  rx_d;
  logic                  start_edge;
  logic [UART_DIV_W-1:0] cnt;
  logic [UART_DIV_W-1:0] div_q;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0]  shift;
  logic [DATA_BITS-1:0]  dout_q;
  logic                  done_q;
  logic                  ferr_q;

  uart_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );

  assign start_edge = rx_d & ~rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RX_IDLE;
      rx_d    <= 1'b1;
      cnt     <= '0;
      div_q   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      rx_d   <= rx_s;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          // a line stuck low shows no edge
          if (start_edge) begin
            state <= RX_START;
            cnt   <= '0;
            div_q <= clk_div;
          end
        end
        RX_START: begin
          if (cnt == (div_q >> 1)) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end else begin
              state <= RX_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == div_q) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state <= RX_STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          // leave at stop centre to catch a
          // start bit that follows directly
          if (cnt == div_q) begin
            cnt   <= '0;
            state <= RX_IDLE;
            if (rx_s) begin
              dout_q <= shift;
              done_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RX_IDLE;
        end
      endcase
    end
  end

  assign dout      = dout_q;
  assign done      = done_q;
  assign frame_err = ferr_q;
  assign busy      = (state != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx.
// Frame-level model schedules expected strobes.
module tb_uart_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx = 1'b1;
  logic [15:0] clk_div = 16'd15;
  logic [7:0]  dout;
  logic        done;
  logic        frame_err;
  logic        busy;

  int vecs = 0;
  int miss = 0;
  int cyc = 0;

  int         ev_kind[int];
  logic [7:0] ev_byte[int];
  int         last_ev = 0;
  logic [7:0] mdout = 8'h00;
  int         last_start = 0;

  logic [7:0] done_bytes[$];
  int         done_cyc[$];
  int         fe_cyc[$];

  uart_rx dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .clk_div  (clk_div),
    .dout     (dout),
    .done     (done),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected strobe time from the frame's
  // start-bit drive cycle: sync + edge + frame
  function automatic int strobe_at(input int n,
                                   input int div);
    return n + 3 + (div >> 1) + 1 + 9 * (div + 1);
  endfunction

  task automatic sched(input int at, input int kind,
                       input logic [7:0] b);
    ev_kind[at] = kind;
    ev_byte[at] = b;
    if (at > last_ev) last_ev = at;
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop,
                            input int div);
    logic [9:0] bits;
    int n;
    n = cyc;
    last_start = n;
    sched(strobe_at(n, div), stop ? 1 : 2, b);
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (div + 1) tick();
    end
  endtask

  task automatic compare_loop();
    logic ed;
    logic ef;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mdout = 8'h00;
        chk("rst_dout", dout, 0);
        chk("rst_done", done, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy, 0);
      end else begin
        ed = 1'b0;
        ef = 1'b0;
        if (ev_kind.exists(cyc)) begin
          if (ev_kind[cyc] == 1) begin
            ed = 1'b1;
            mdout = ev_byte[cyc];
          end else begin
            ef = 1'b1;
          end
        end
        chk("done", done, ed);
        chk("frame_err", frame_err, ef);
        chk("dout", dout, mdout);
        if (done) begin
          done_bytes.push_back(dout);
          done_cyc.push_back(cyc);
        end
        if (frame_err) fe_cyc.push_back(cyc);
      end
    end
  endtask

  initial begin
    int nd;
    int nf;
    int n;
    logic [7:0] b55;
    logic [7:0] exp4[3];

    fork
      compare_loop();
    join_none

    rst = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    repeat (20) tick();
    chk("reset_dout", dout, 0);
    chk("reset_busy", busy, 0);

    // 1: good frame
    nd = done_bytes.size();
    fork
      send_frame(8'hA5, 1'b1, 15);
      begin
        repeat (40) tick();
        chk("t1_busy_mid", busy, 1);
      end
    join
    repeat (32) tick();
    chk("t1_count", done_bytes.size(), nd + 1);
    if (done_bytes.size() > nd) begin
      chk("t1_byte", done_bytes[nd], 8'hA5);
      chk("t1_latency", done_cyc[nd] - last_start, 155);
    end
    chk("t1_busy_after", busy, 0);

    // 2: short glitch
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (40) tick();
    chk("t2_count", done_bytes.size(), nd + 1);
    chk("t2_ferr", fe_cyc.size(), 0);
    chk("t2_busy", busy, 0);
    chk("t2_dout", dout, 8'hA5);

    // 3: bad stop bit
    send_frame(8'h3C, 1'b0, 15);
    rx = 1'b1;
    repeat (32) tick();
    chk("t3_ferr", fe_cyc.size(), 1);
    chk("t3_count", done_bytes.size(), nd + 1);
    chk("t3_dout", dout, 8'hA5);

    // 4: back-to-back frames
    nd = done_bytes.size();
    exp4[0] = 8'h00;
    exp4[1] = 8'hFF;
    exp4[2] = 8'h81;
    for (int i = 0; i < 3; i++) send_frame(exp4[i], 1'b1, 15);
    repeat (32) tick();
    chk("t4_count", done_bytes.size(), nd + 3);
    if (done_bytes.size() >= nd + 3) begin
      for (int i = 0; i < 3; i++)
        chk("t4_byte", done_bytes[nd+i], exp4[i]);
    end

    // 5: reset in the middle of a frame
    nd = done_bytes.size();
    b55 = 8'h55;
    rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 3; i++) begin
      rx = b55[i];
      repeat (16) tick();
    end
    rst = 1'b0;
    rx = 1'b1;
    repeat (5) tick();
    chk("t5_busy_rst", busy, 0);
    chk("t5_dout_rst", dout, 0);
    rst = 1'b1;
    repeat (40) tick();
    chk("t5_no_strobe", done_bytes.size(), nd);
    send_frame(8'h12, 1'b1, 15);
    repeat (32) tick();
    chk("t5_count", done_bytes.size(), nd + 1);
    if (done_bytes.size() > nd)
      chk("t5_byte", done_bytes[nd], 8'h12);

    // clk_div changed mid-frame is ignored
    nd = done_bytes.size();
    fork
      send_frame(8'hC3, 1'b1, 15);
      begin
        repeat (60) tick();
        clk_div = 16'd40;
      end
    join
    repeat (32) tick();
    clk_div = 16'd15;
    chk("div_chg_count", done_bytes.size(), nd + 1);
    if (done_bytes.size() > nd)
      chk("div_chg_byte", done_bytes[nd], 8'hC3);

    // smallest legal divider
    nd = done_bytes.size();
    clk_div = 16'd3;
    repeat (4) tick();
    send_frame(8'h96, 1'b1, 3);
    repeat (20) tick();
    chk("div3_count", done_bytes.size(), nd + 1);
    if (done_bytes.size() > nd) begin
      chk("div3_byte", done_bytes[nd], 8'h96);
      chk("div3_latency", done_cyc[nd] - last_start, 41);
    end

    // 6: break then frame at slow rate
    clk_div = 16'd103;
    repeat (4) tick();
    nf = fe_cyc.size();
    nd = done_bytes.size();
    n = cyc;
    sched(strobe_at(n, 103), 2, 8'h00);
    rx = 1'b0;
    repeat (40 * 104) tick();
    rx = 1'b1;
    repeat (2 * 104) tick();
    chk("t6_break_ferr", fe_cyc.size(), nf + 1);
    send_frame(8'h7E, 1'b1, 103);
    repeat (2 * 104) tick();
    chk("t6_ferr_total", fe_cyc.size(), nf + 1);
    chk("t6_count", done_bytes.size(), nd + 1);
    if (done_bytes.size() > nd) begin
      chk("t6_byte", done_bytes[nd], 8'h7E);
      chk("t6_latency", done_cyc[nd] - last_start, 991);
    end
    chk("t6_busy", busy, 0);
    chk("all_events_seen", cyc > last_ev, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
